// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and validity check for the N-digit BCD counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: loads (invalid digits become 0) or steps up/down with 9<->0 roll.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step_en,
    input  logic       up,
    input  bcd_digit_t load_d,
    input  logic       load,
    output bcd_digit_t q,
    output logic       at_max,
    output logic       at_min
);

    bcd_digit_t r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= BCD_MIN;
        end else if (load) begin
            r_q <= is_bcd(load_d) ? load_d : BCD_MIN;
        end else if (step_en) begin
            if (up) begin
                r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
            end else begin
                r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
            end
        end
    end

    assign q      = r_q;
    assign at_max = (r_q == BCD_MAX);
    assign at_min = (r_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with parallel load, wrap or saturate at the terminal count,
// and registered carry/borrow, saturation and load-error flags.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned NDIGITS = 4,
    parameter bit          WRAP    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   up,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_val,
    output logic [4*NDIGITS-1:0]   count,
    output logic                   carry,
    output logic                   sat,
    output logic                   load_err
);

    logic [NDIGITS-1:0] w_at_max, w_at_min, w_step_en;
    logic [NDIGITS-1:0] w_bad, w_ld9, w_ld0;
    // w_chain_*[i]: every digit below position i sits at its limit
    logic [NDIGITS:0]   w_chain_max, w_chain_min;
    logic               w_term, w_advance, w_hi_max, w_hi_min, w_reach;

    logic r_carry, r_sat, r_load_err;

    assign w_chain_max[0] = 1'b1;
    assign w_chain_min[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
            assign w_chain_max[gi+1] = w_chain_max[gi] & w_at_max[gi];
            assign w_chain_min[gi+1] = w_chain_min[gi] & w_at_min[gi];
            assign w_step_en[gi]     = w_advance & (up ? w_chain_max[gi] : w_chain_min[gi]);

            assign w_bad[gi] = !is_bcd(load_val[4*gi +: 4]);
            assign w_ld9[gi] = (load_val[4*gi +: 4] == BCD_MAX);
            assign w_ld0[gi] = (load_val[4*gi +: 4] == BCD_MIN) | w_bad[gi];

            bcd_digit u_digit (
                .clk     (clk),
                .reset   (reset),
                .step_en (w_step_en[gi]),
                .up      (up),
                .load_d  (load_val[4*gi +: 4]),
                .load    (load),
                .q       (count[4*gi +: 4]),
                .at_max  (w_at_max[gi]),
                .at_min  (w_at_min[gi])
            );
        end
    endgenerate

    assign w_term    = up ? w_chain_max[NDIGITS] : w_chain_min[NDIGITS];
    assign w_advance = en & ~(~WRAP & w_term);

    // The terminal is reached next edge when digit 0 is one step short and all others are at the limit
    always_comb begin
        w_hi_max = 1'b1;
        w_hi_min = 1'b1;
        for (int unsigned i = 1; i < NDIGITS; i++) begin
            w_hi_max = w_hi_max & w_at_max[i];
            w_hi_min = w_hi_min & w_at_min[i];
        end
        w_reach = up ? ((count[3:0] == 4'd8) & w_hi_max)
                     : ((count[3:0] == 4'd1) & w_hi_min);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_carry    <= 1'b0;
            r_sat      <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load) begin
            r_carry    <= 1'b0;
            r_load_err <= |w_bad;
            r_sat      <= ~WRAP & ((&w_ld9) | (&w_ld0));
        end else begin
            r_load_err <= 1'b0;
            r_carry    <= en & (WRAP ? w_term : w_reach);
            if (en) begin
                r_sat <= ~WRAP & (w_term | w_reach);
            end
        end
    end

    assign carry    = r_carry;
    assign sat      = r_sat;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed and model-checked random stimulus for bcd_counter_n in three configurations.
module tb_bcd_counter_n;

    logic        clk = 1'b0;
    logic        reset, en, up, load;
    logic [31:0] lv;

    logic [7:0]  count2;
    logic [11:0] count3;
    logic [15:0] count4;
    logic        carry2, sat2, err2, carry3, sat3, err3, carry4, sat4, err4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_counter_n #(.NDIGITS(2), .WRAP(1'b1)) d2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
        .count(count2), .carry(carry2), .sat(sat2), .load_err(err2)
    );
    bcd_counter_n #(.NDIGITS(3), .WRAP(1'b1)) d3 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[11:0]),
        .count(count3), .carry(carry3), .sat(sat3), .load_err(err3)
    );
    bcd_counter_n #(.NDIGITS(4), .WRAP(1'b0)) d4 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(lv[15:0]),
        .count(count4), .carry(carry4), .sat(sat4), .load_err(err4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] to_bcd(input int v, input int n);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Decimal-integer reference model of one counter configuration
    task automatic model_step(input int n, input bit wrap, input logic [31:0] m_lv,
                              inout int v, inout bit s, output bit c, output bit e);
        int mx = 1;
        int d;
        for (int i = 0; i < n; i++) mx = mx * 10;
        mx = mx - 1;
        c = 1'b0;
        e = 1'b0;
        if (load) begin
            v = 0;
            for (int i = n - 1; i >= 0; i--) begin
                d = int'(m_lv[4*i +: 4]);
                if (d > 9) begin
                    e = 1'b1;
                    d = 0;
                end
                v = v * 10 + d;
            end
            s = !wrap && (v == mx || v == 0);
        end else if (en) begin
            if (up) begin
                if (v == mx) begin
                    if (wrap) begin v = 0; c = 1'b1; end
                end else begin
                    v = v + 1;
                    c = !wrap && (v == mx);
                end
                s = !wrap && (v == mx);
            end else begin
                if (v == 0) begin
                    if (wrap) begin v = mx; c = 1'b1; end
                end else begin
                    v = v - 1;
                    c = !wrap && (v == 0);
                end
                s = !wrap && (v == 0);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = '0;
        step();
        checks++; if (count2 !== 8'h00) begin errors++; $display("FAIL reset_count2 got=%h exp=00", count2); end
        checks++; if (count3 !== 12'h000) begin errors++; $display("FAIL reset_count3 got=%h exp=000", count3); end
        checks++; if (count4 !== 16'h0000) begin errors++; $display("FAIL reset_count4 got=%h exp=0000", count4); end
        checks++; if ({carry2, sat2, err2, carry4, sat4, err4} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=000000", {carry2, sat2, err2, carry4, sat4, err4});
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap_up();
        logic [31:0] exp;
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            exp = to_bcd(k % 100, 2);
            checks++; if (count2 !== exp[7:0]) begin errors++; $display("FAIL wrap_up_count k=%0d got=%h exp=%h", k, count2, exp[7:0]); end
            checks++; if (carry2 !== (k == 100)) begin errors++; $display("FAIL wrap_up_carry k=%0d got=%b exp=%b", k, carry2, (k == 100)); end
        end
    endtask

    task automatic test_wrap_down();
        up = 1'b0;
        step();
        checks++; if (count2 !== 8'h99) begin errors++; $display("FAIL down_wrap_count got=%h exp=99", count2); end
        checks++; if (carry2 !== 1'b1) begin errors++; $display("FAIL down_wrap_carry got=%b exp=1", carry2); end
        step();
        checks++; if (count2 !== 8'h98 || carry2 !== 1'b0) begin errors++; $display("FAIL down_98 got=%h/%b exp=98/0", count2, carry2); end
        step();
        checks++; if (count2 !== 8'h97 || carry2 !== 1'b0) begin errors++; $display("FAIL down_97 got=%h/%b exp=97/0", count2, carry2); end
        en = 1'b0;
    endtask

    task automatic test_load_err();
        load = 1'b1; en = 1'b1; up = 1'b1; lv = 32'h0000_01A5;
        step();
        checks++; if (count3 !== 12'h105) begin errors++; $display("FAIL load_sanitize got=%h exp=105", count3); end
        checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL load_err_set got=%b exp=1", err3); end
        checks++; if (carry3 !== 1'b0) begin errors++; $display("FAIL load_carry got=%b exp=0", carry3); end
        load = 1'b0; en = 1'b0;
        step();
        checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL load_err_pulse got=%b exp=0", err3); end
        checks++; if (count3 !== 12'h105) begin errors++; $display("FAIL load_hold got=%h exp=105", count3); end
    endtask

    task automatic test_saturate();
        load = 1'b1; en = 1'b0; lv = 32'h0000_9998;
        step();
        checks++; if (count4 !== 16'h9998 || sat4 !== 1'b0 || err4 !== 1'b0) begin
            errors++; $display("FAIL sat_load got=%h/%b/%b exp=9998/0/0", count4, sat4, err4);
        end
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        checks++; if (count4 !== 16'h9999 || carry4 !== 1'b1 || sat4 !== 1'b1) begin
            errors++; $display("FAIL sat_reach got=%h/%b/%b exp=9999/1/1", count4, carry4, sat4);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (count4 !== 16'h9999 || carry4 !== 1'b0 || sat4 !== 1'b1) begin
                errors++; $display("FAIL sat_hold k=%0d got=%h/%b/%b exp=9999/0/1", k, count4, carry4, sat4);
            end
        end
        up = 1'b0;
        step();
        checks++; if (count4 !== 16'h9998 || carry4 !== 1'b0 || sat4 !== 1'b0) begin
            errors++; $display("FAIL sat_leave got=%h/%b/%b exp=9998/0/0", count4, carry4, sat4);
        end
        load = 1'b1; en = 1'b0; lv = 32'h0000_0001;
        step();
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        checks++; if (count4 !== 16'h0000 || carry4 !== 1'b1 || sat4 !== 1'b1) begin
            errors++; $display("FAIL sat_min_reach got=%h/%b/%b exp=0000/1/1", count4, carry4, sat4);
        end
        step();
        checks++; if (count4 !== 16'h0000 || carry4 !== 1'b0 || sat4 !== 1'b1) begin
            errors++; $display("FAIL sat_min_hold got=%h/%b/%b exp=0000/0/1", count4, carry4, sat4);
        end
        load = 1'b1; en = 1'b0; lv = 32'h0000_9999;
        step();
        checks++; if (count4 !== 16'h9999 || sat4 !== 1'b1 || carry4 !== 1'b0) begin
            errors++; $display("FAIL sat_load_max got=%h/%b/%b exp=9999/1/0", count4, sat4, carry4);
        end
        load = 1'b0;
    endtask

    task automatic test_reset_override();
        load = 1'b1; en = 1'b0; lv = 32'h0000_0459;
        step();
        checks++; if (count4 !== 16'h0459) begin errors++; $display("FAIL pre_reset_load got=%h exp=0459", count4); end
        reset = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; lv = 32'h0000_AAAA;
        step();
        checks++; if (count4 !== 16'h0000 || carry4 !== 1'b0 || sat4 !== 1'b0 || err4 !== 1'b0) begin
            errors++; $display("FAIL reset_override got=%h/%b/%b/%b exp=0000/0/0/0", count4, carry4, sat4, err4);
        end
        checks++; if (count3 !== 12'h000 || err3 !== 1'b0) begin
            errors++; $display("FAIL reset_override3 got=%h/%b exp=000/0", count3, err3);
        end
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_random();
        int  v2 = 0, v4 = 0;
        bit  s2 = 1'b0, s4 = 1'b0, c2, c4, e2, e4;
        bit  bad;
        logic [31:0] x2, x4;
        reset = 1'b1; load = 1'b0; en = 1'b0;
        step();
        reset = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) != 0;
            load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       lv = 32'h0000_9997;
                1:       lv = 32'h0000_0002;
                default: lv = $urandom;
            endcase
            step();
            model_step(2, 1'b1, lv, v2, s2, c2, e2);
            model_step(4, 1'b0, lv, v4, s4, c4, e4);
            x2 = to_bcd(v2, 2);
            x4 = to_bcd(v4, 4);
            checks++; if (count2 !== x2[7:0] || carry2 !== c2 || sat2 !== s2 || err2 !== e2) begin
                errors++; $display("FAIL rand2 cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", cyc, count2, carry2, sat2, err2, x2[7:0], c2, s2, e2);
            end
            checks++; if (count4 !== x4[15:0] || carry4 !== c4 || sat4 !== s4 || err4 !== e4) begin
                errors++; $display("FAIL rand4 cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", cyc, count4, carry4, sat4, err4, x4[15:0], c4, s4, e4);
            end
            bad = 1'b0;
            for (int i = 0; i < 4; i++) if (count4[4*i +: 4] > 4'd9) bad = 1'b1;
            for (int i = 0; i < 2; i++) if (count2[4*i +: 4] > 4'd9) bad = 1'b1;
            checks++; if (bad !== 1'b0) begin
                errors++; $display("FAIL digit_range cyc=%0d got=%h/%h exp=digits<=9", cyc, count2, count4);
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_load_err();
        test_saturate();
        test_reset_override();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
